// File: rtl/spi_block_packer.sv
// Byte/block adapter between an SPI slave and the AES core: packs 16 received
// bytes into a 128-bit block and serialises a 128-bit result back out as bytes.
module spi_block_packer #(
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         slave_done,
    input  logic [7:0]   rx_byte,
    output logic [7:0]   tx_byte,
    input  logic         flush,
    output logic [127:0] blk_out,
    output logic         blk_out_valid,
    input  logic         blk_out_ready,
    input  logic [127:0] blk_in,
    input  logic         blk_in_valid,
    output logic         blk_in_ready,
    output logic         overrun
);

    typedef enum logic [0:0] {RX_COLLECT = 1'b0, RX_HOLD = 1'b1} rx_state_t;
    typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;

    logic           done_d_r;
    logic           ev_s;
    rx_state_t      rx_state_r, rx_state_s;
    logic [3:0]     rx_cnt_r, rx_cnt_s;
    logic [127:0]   blk_out_r, blk_out_s;
    logic           blk_out_valid_r, blk_out_valid_s;
    logic           overrun_r, overrun_s;
    tx_state_t      tx_state_r, tx_state_s;
    logic [3:0]     tx_cnt_r, tx_cnt_s;
    logic [127:0]   shift_r, shift_s;
    logic [7:0]     tx_byte_r, tx_byte_s;
    logic           blk_in_ready_r, blk_in_ready_s;

    assign ev_s = slave_done & ~done_d_r;

    // Receive side: byte assembly, hand-off to the cipher, overrun detection
    always_comb begin
        rx_state_s      = rx_state_r;
        rx_cnt_s        = rx_cnt_r;
        blk_out_s       = blk_out_r;
        blk_out_valid_s = blk_out_valid_r;
        overrun_s       = 1'b0;
        if (flush) begin
            rx_state_s      = RX_COLLECT;
            rx_cnt_s        = 4'd0;
            blk_out_valid_s = 1'b0;
        end else begin
            case (rx_state_r)
                RX_COLLECT: begin
                    if (ev_s) begin
                        blk_out_s = {blk_out_r[119:0], rx_byte};
                        rx_cnt_s  = rx_cnt_r + 4'd1;
                        if (rx_cnt_r == 4'd15) begin
                            rx_state_s      = RX_HOLD;
                            blk_out_valid_s = 1'b1;
                        end else begin
                            rx_state_s = RX_COLLECT;
                        end
                    end else begin
                        rx_state_s = RX_COLLECT;
                    end
                end
                RX_HOLD: begin
                    if (blk_out_ready) begin
                        rx_state_s      = RX_COLLECT;
                        blk_out_valid_s = 1'b0;
                        // A byte arriving with the hand-off starts the next block
                        if (ev_s) begin
                            blk_out_s = {blk_out_r[119:0], rx_byte};
                            rx_cnt_s  = 4'd1;
                        end else begin
                            rx_cnt_s = 4'd0;
                        end
                    end else if (ev_s) begin
                        overrun_s = 1'b1;
                    end else begin
                        rx_state_s = RX_HOLD;
                    end
                end
                default: begin
                    rx_state_s      = RX_COLLECT;
                    rx_cnt_s        = 4'd0;
                    blk_out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // Transmit side: block load and byte-per-event serialisation
    always_comb begin
        tx_state_s     = tx_state_r;
        tx_cnt_s       = tx_cnt_r;
        shift_s        = shift_r;
        tx_byte_s      = tx_byte_r;
        blk_in_ready_s = blk_in_ready_r;
        if (flush) begin
            tx_state_s     = TX_IDLE;
            tx_cnt_s       = 4'd0;
            tx_byte_s      = FILL;
            blk_in_ready_s = 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (blk_in_valid) begin
                        shift_s        = blk_in;
                        tx_cnt_s       = 4'd0;
                        tx_state_s     = TX_SEND;
                        tx_byte_s      = blk_in[127:120];
                        blk_in_ready_s = 1'b0;
                    end else begin
                        tx_byte_s      = FILL;
                        blk_in_ready_s = 1'b1;
                    end
                end
                TX_SEND: begin
                    if (ev_s) begin
                        shift_s  = {shift_r[119:0], 8'h00};
                        tx_cnt_s = tx_cnt_r + 4'd1;
                        if (tx_cnt_r == 4'd15) begin
                            tx_state_s     = TX_IDLE;
                            tx_byte_s      = FILL;
                            blk_in_ready_s = 1'b1;
                        end else begin
                            tx_byte_s = shift_r[119:112];
                        end
                    end else begin
                        tx_state_s = TX_SEND;
                    end
                end
                default: begin
                    tx_state_s     = TX_IDLE;
                    tx_cnt_s       = 4'd0;
                    tx_byte_s      = FILL;
                    blk_in_ready_s = 1'b1;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_d_r        <= 1'b0;
            rx_state_r      <= RX_COLLECT;
            rx_cnt_r        <= 4'd0;
            blk_out_r       <= 128'd0;
            blk_out_valid_r <= 1'b0;
            overrun_r       <= 1'b0;
            tx_state_r      <= TX_IDLE;
            tx_cnt_r        <= 4'd0;
            shift_r         <= 128'd0;
            tx_byte_r       <= FILL;
            blk_in_ready_r  <= 1'b1;
        end else begin
            done_d_r        <= slave_done;
            rx_state_r      <= rx_state_s;
            rx_cnt_r        <= rx_cnt_s;
            blk_out_r       <= blk_out_s;
            blk_out_valid_r <= blk_out_valid_s;
            overrun_r       <= overrun_s;
            tx_state_r      <= tx_state_s;
            tx_cnt_r        <= tx_cnt_s;
            shift_r         <= shift_s;
            tx_byte_r       <= tx_byte_s;
            blk_in_ready_r  <= blk_in_ready_s;
        end
    end

    assign blk_out       = blk_out_r;
    assign blk_out_valid = blk_out_valid_r;
    assign overrun       = overrun_r;
    assign tx_byte       = tx_byte_r;
    assign blk_in_ready  = blk_in_ready_r;

endmodule
